// File: rtl/alu_cmd_sequencer.sv
// Registered request/response front end for a combinational 32-bit ALU.
// Holds ALU inputs for SETTLE_CYCLES, then captures result and flags into a tagged response.
module alu_cmd_sequencer #(
    parameter int SETTLE_CYCLES = 1,
    parameter int TAG_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    // valid/ready: a transfer happens on a rising edge where valid and ready are both high;
    // the sender holds valid and payload stable until that edge.
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [31:0]      alu_data1,
    output logic [31:0]      alu_data2,
    output logic [3:0]       alu_op,
    input  logic [31:0]      alu_result,
    input  logic             alu_zero,
    input  logic             alu_lt,
    input  logic             alu_gt,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic             rsp_zero,
    output logic             rsp_lt,
    output logic             rsp_gt,
    output logic             rsp_err,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [15:0]      op_count,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic [31:0]       data1_q;
    logic [31:0]       data2_q;
    logic [3:0]        op_q;
    logic [TAG_W-1:0]  tag_q;
    logic              err_q;
    logic              eq_q;
    logic              rsp_valid_q;
    logic [31:0]       rsp_result_q;
    logic              rsp_zero_q;
    logic              rsp_lt_q;
    logic              rsp_gt_q;
    logic              rsp_err_q;
    logic [TAG_W-1:0]  rsp_tag_q;
    logic [15:0]       op_count_q;
    logic [15:0]       op_count_d;
    logic              cmd_fire;
    logic              rsp_fire;

    assign cmd_ready  = rst_n & ((state_q == S_IDLE) | ((state_q == S_RESP) & rsp_ready));
    assign cmd_fire   = cmd_valid & cmd_ready;
    assign rsp_fire   = rsp_valid_q & rsp_ready;
    assign op_count_d = rsp_fire ? op_count_q + 16'd1 : op_count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            data1_q      <= '0;
            data2_q      <= '0;
            op_q         <= '0;
            tag_q        <= '0;
            err_q        <= 1'b0;
            eq_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_lt_q     <= 1'b0;
            rsp_gt_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_tag_q    <= '0;
            op_count_q   <= '0;
        end else begin
            op_count_q <= op_count_d;
            if (cmd_fire) begin
                // Illegal opcodes run as ADD; only the error flag records them.
                data1_q     <= cmd_a;
                data2_q     <= cmd_b;
                op_q        <= (cmd_op > 4'd5) ? 4'd0 : cmd_op;
                err_q       <= (cmd_op > 4'd5);
                eq_q        <= (cmd_a == cmd_b);
                tag_q       <= cmd_tag;
                cnt_q       <= CNT_LOAD;
                rsp_valid_q <= 1'b0;
                state_q     <= S_WAIT;
            end else begin
                case (state_q)
                    S_WAIT: begin
                        if (cnt_q == 4'd0) begin
                            // The ALU leaves lt/gt stale on equal operands, so force them low.
                            rsp_result_q <= alu_result;
                            rsp_zero_q   <= alu_zero;
                            rsp_lt_q     <= eq_q ? 1'b0 : alu_lt;
                            rsp_gt_q     <= eq_q ? 1'b0 : alu_gt;
                            rsp_err_q    <= err_q;
                            rsp_tag_q    <= tag_q;
                            rsp_valid_q  <= 1'b1;
                            state_q      <= S_RESP;
                        end else begin
                            cnt_q <= cnt_q - 4'd1;
                        end
                    end
                    S_RESP: begin
                        if (rsp_ready) begin
                            rsp_valid_q <= 1'b0;
                            state_q     <= S_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign alu_data1  = data1_q;
    assign alu_data2  = data2_q;
    assign alu_op     = op_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_lt     = rsp_lt_q;
    assign rsp_gt     = rsp_gt_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_tag    = rsp_tag_q;
    assign op_count   = op_count_q;
    assign dbg_state  = state_q;

endmodule
